// File: rtl/pool_result_writer_pkg.sv
// Shared types for the pool result writer: FSM encoding, default geometry and FIFO entry layout.
package pool_result_writer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } wr_state_e;

   localparam int PRW_MAT_MUL_SIZE = 4;
   localparam int PRW_DWIDTH       = 8;
   localparam int PRW_AWIDTH       = 10;
   localparam int PRW_MASK_WIDTH   = 4;
   localparam int PRW_FIFO_DEPTH   = 4;
   localparam int PRW_ROW_W        = PRW_MAT_MUL_SIZE * PRW_DWIDTH;

   // Entry layout at the default geometry; the top rebuilds the same layout from its parameters.
   typedef struct packed {
      logic [PRW_ROW_W-1:0]      data;
      logic [PRW_MASK_WIDTH-1:0] mask;
   } row_entry_t;

endpackage

// File: rtl/pool_result_writer_if.sv
// BRAM C write port as seen by the pool result writer (master) and the BRAM arbiter (slave).
interface pool_result_writer_if #(
   parameter int AWIDTH     = 10,
   parameter int MASK_WIDTH = 4,
   parameter int ROW_W      = 32
);
   logic                  bram_req_c;
   logic                  bram_gnt_c;
   logic                  bram_en_c;
   logic [MASK_WIDTH-1:0] bram_we_c;
   logic [AWIDTH-1:0]     bram_addr_c;
   logic [ROW_W-1:0]      bram_wdata_c;

   modport master (
      output bram_req_c, bram_en_c, bram_we_c, bram_addr_c, bram_wdata_c,
      input  bram_gnt_c
   );

   modport slave (
      input  bram_req_c, bram_en_c, bram_we_c, bram_addr_c, bram_wdata_c,
      output bram_gnt_c
   );
endinterface

// File: rtl/pool_result_writer_row_fifo.sv
// pool_row_fifo: synchronous first-word-fall-through FIFO; pointers carry an extra wrap bit.
module pool_row_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW:0]      r_wptr;
   logic [PW:0]      r_rptr;

   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
   assign o_rdata = r_mem[r_rptr[PW-1:0]];

   // Caller guarantees push only with room (or a same-cycle pop) and pop only when non-empty.
   always_ff @(posedge clk) begin
      if (!resetn || i_flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + 1'b1;
         if (i_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wptr[PW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/pool_result_writer.sv
// Buffers pooled rows and commits them to BRAM C at base + n*stride, raising done after num_rows.
// Optional POOL_WRITER_STALL_CNT_EN adds a saturating stall_cycles counter of denied-grant cycles.
module pool_result_writer
   import pool_result_writer_pkg::*;
#(
   parameter int MAT_MUL_SIZE = PRW_MAT_MUL_SIZE,
   parameter int DWIDTH       = PRW_DWIDTH,
   parameter int AWIDTH       = PRW_AWIDTH,
   parameter int MASK_WIDTH   = PRW_MASK_WIDTH,
   parameter int FIFO_DEPTH   = PRW_FIFO_DEPTH
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           enable_writer,
   input  logic                           start,
   input  logic [AWIDTH-1:0]              base_addr_c,
   input  logic [AWIDTH-1:0]              stride_c,
   input  logic [AWIDTH-1:0]              num_rows,
   input  logic [MASK_WIDTH-1:0]          validity_mask,
   input  logic                           in_data_available,
   input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
   pool_result_writer_if.master           bram,
   output logic                           overflow,
   output logic                           done_writer
`ifdef POOL_WRITER_STALL_CNT_EN
   ,
   output logic [31:0]                    stall_cycles
`endif
);
   localparam int RW = MAT_MUL_SIZE * DWIDTH;

   typedef struct packed {
      logic [RW-1:0]         data;
      logic [MASK_WIDTH-1:0] mask;
   } entry_t;

   wr_state_e         r_state;
   wr_state_e         w_state_nxt;
   logic [AWIDTH-1:0] r_stride;
   logic [AWIDTH-1:0] r_num_rows;
   logic [AWIDTH-1:0] r_rows_in;
   logic [AWIDTH-1:0] r_rows_out;
   logic [AWIDTH-1:0] r_addr;
   logic              r_overflow;

   entry_t            w_wentry;
   entry_t            w_head;
   logic              w_start;
   logic              w_active;
   logic              w_req;
   logic              w_pop;
   logic              w_push_req;
   logic              w_push;
   logic              w_full;
   logic              w_empty;
   logic [AWIDTH-1:0] w_rows_in_nxt;
   logic [AWIDTH-1:0] w_rows_out_nxt;

   assign w_start    = enable_writer & start;
   assign w_active   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign w_req      = w_active & ~w_empty;
   assign w_pop      = w_req & bram.bram_gnt_c;
   assign w_push_req = enable_writer & in_data_available & (r_state == ST_RUN)
                       & (r_rows_in != r_num_rows) & ~w_start;
   // A full FIFO still accepts the row when the head leaves in the same cycle.
   assign w_push     = w_push_req & (~w_full | w_pop);

   assign w_rows_in_nxt  = r_rows_in  + {{(AWIDTH-1){1'b0}}, w_push};
   assign w_rows_out_nxt = r_rows_out + {{(AWIDTH-1){1'b0}}, w_pop};

   assign w_wentry.data = inp_data;
   assign w_wentry.mask = validity_mask;

   pool_row_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_flush (w_start),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_wentry),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Look-ahead on the counters so done rises the cycle after the final write.
   always_comb begin
      w_state_nxt = r_state;
      if (w_start) begin
         w_state_nxt = (num_rows == '0) ? ST_DONE : ST_RUN;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_rows_out_nxt == r_num_rows)     w_state_nxt = ST_DONE;
               else if (w_rows_in_nxt == r_num_rows) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
               if (w_rows_out_nxt == r_num_rows) w_state_nxt = ST_DONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_stride   <= '0;
         r_num_rows <= '0;
         r_rows_in  <= '0;
         r_rows_out <= '0;
         r_addr     <= '0;
         r_overflow <= 1'b0;
      end else if (w_start) begin
         r_stride   <= stride_c;
         r_num_rows <= num_rows;
         r_rows_in  <= '0;
         r_rows_out <= '0;
         r_addr     <= base_addr_c;
         r_overflow <= 1'b0;
      end else begin
         r_rows_in  <= w_rows_in_nxt;
         r_rows_out <= w_rows_out_nxt;
         if (w_pop) r_addr <= r_addr + r_stride;
         if (w_push_req & w_full & ~w_pop) r_overflow <= 1'b1;
      end
   end

   // Bus fields are forced to zero when no row is offered, so an empty FIFO shows a quiet port.
   assign bram.bram_req_c   = w_req;
   assign bram.bram_en_c    = w_pop;
   assign bram.bram_we_c    = w_req ? w_head.mask : '0;
   assign bram.bram_addr_c  = w_req ? r_addr      : '0;
   assign bram.bram_wdata_c = w_req ? w_head.data : '0;
   assign overflow          = r_overflow;
   assign done_writer       = (r_state == ST_DONE);

`ifdef POOL_WRITER_STALL_CNT_EN
   logic [31:0] r_stall;

   always_ff @(posedge clk) begin
      if (!resetn || w_start) r_stall <= '0;
      else if (w_req & ~bram.bram_gnt_c & ~(&r_stall)) r_stall <= r_stall + 32'd1;
   end

   assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_pool_result_writer.sv
// Directed bench for pool_result_writer: scoreboard of expected BRAM writes plus timing/flag checks.
module tb_pool_result_writer;
   import pool_result_writer_pkg::*;

   localparam int MMS = 4;
   localparam int DW  = 8;
   localparam int AW  = 10;
   localparam int MW  = 4;
   localparam int FD  = 4;
   localparam int RW  = MMS * DW;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          enable_writer = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr_c = '0;
   logic [AW-1:0] stride_c = '0;
   logic [AW-1:0] num_rows = '0;
   logic [MW-1:0] validity_mask = '0;
   logic          in_data_available = 1'b0;
   logic [RW-1:0] inp_data = '0;
   logic          overflow;
   logic          done_writer;
`ifdef POOL_WRITER_STALL_CNT_EN
   logic [31:0]   stall_cycles;
`endif

   pool_result_writer_if #(.AWIDTH(AW), .MASK_WIDTH(MW), .ROW_W(RW)) bram_if ();

   always #5 clk = ~clk;

   pool_result_writer #(
      .MAT_MUL_SIZE (MMS),
      .DWIDTH       (DW),
      .AWIDTH       (AW),
      .MASK_WIDTH   (MW),
      .FIFO_DEPTH   (FD)
   ) dut (
      .clk               (clk),
      .resetn            (resetn),
      .enable_writer     (enable_writer),
      .start             (start),
      .base_addr_c       (base_addr_c),
      .stride_c          (stride_c),
      .num_rows          (num_rows),
      .validity_mask     (validity_mask),
      .in_data_available (in_data_available),
      .inp_data          (inp_data),
      .bram              (bram_if.master),
      .overflow          (overflow),
      .done_writer       (done_writer)
`ifdef POOL_WRITER_STALL_CNT_EN
      ,
      .stall_cycles      (stall_cycles)
`endif
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [MW-1:0] we;
      logic [RW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   int            total = 0;
   int            bad = 0;
   int            writes = 0;
   logic [AW-1:0] m_addr = '0;
   logic [AW-1:0] m_stride = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every BRAM write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (bram_if.bram_en_c === 1'b1) begin
         writes++;
         total++;
         assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_write observed addr=%0h expected none", bram_if.bram_addr_c);
         end
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("bram_write", {bram_if.bram_addr_c, bram_if.bram_we_c, bram_if.bram_wdata_c}, e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [AW-1:0] n);
      start = 1'b1; base_addr_c = b; stride_c = s; num_rows = n;
      m_addr = b; m_stride = s;
      step();
      start = 1'b0;
   endtask

   task automatic drive_row(input logic [RW-1:0] d, input logic [MW-1:0] m, input bit acc);
      in_data_available = 1'b1; inp_data = d; validity_mask = m;
      if (acc) begin
         sb.push_back({m_addr, m, d});
         m_addr = m_addr + m_stride;
      end
   endtask

   task automatic push_row(input logic [RW-1:0] d, input logic [MW-1:0] m, input bit acc);
      drive_row(d, m, acc);
      step();
      in_data_available = 1'b0;
   endtask

   initial begin
      bram_if.bram_gnt_c = 1'b0;
      step(); step();
      @(negedge clk);
      chk("rst_req", bram_if.bram_req_c, 1'b0);
      chk("rst_en", bram_if.bram_en_c, 1'b0);
      chk("rst_we", bram_if.bram_we_c, '0);
      chk("rst_addr", bram_if.bram_addr_c, '0);
      chk("rst_wdata", bram_if.bram_wdata_c, '0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_done", done_writer, 1'b0);
      step();
      resetn = 1'b1; enable_writer = 1'b1;

      // Back-to-back rows, grant always high: one write per cycle starting the cycle after push.
      bram_if.bram_gnt_c = 1'b1;
      do_start(10'h010, 10'd4, 10'd3);
      drive_row(32'h11223344, 4'hF, 1'b1);
      @(negedge clk); chk("t1_no_write_push_cycle", bram_if.bram_en_c, 1'b0);
      step();
      drive_row(32'h55667788, 4'hF, 1'b1);
      @(negedge clk); chk("t1_write0", bram_if.bram_en_c, 1'b1);
      step();
      drive_row(32'h99AABBCC, 4'hF, 1'b1);
      @(negedge clk); chk("t1_write1", bram_if.bram_en_c, 1'b1);
      step();
      in_data_available = 1'b0;
      @(negedge clk); chk("t1_write2", bram_if.bram_en_c, 1'b1);
      chk("t1_done_early", done_writer, 1'b0);
      step();
      @(negedge clk); chk("t1_done", done_writer, 1'b1);
      chk("t1_idle_bus", bram_if.bram_en_c, 1'b0);
      step();

      // Grant withheld: fifth row overflows a depth-4 buffer and is lost.
      bram_if.bram_gnt_c = 1'b0;
      do_start(10'h040, 10'd1, 10'd8);
      push_row(32'hA0000001, 4'hF, 1'b1);
      push_row(32'hA0000002, 4'hF, 1'b1);
      push_row(32'hA0000003, 4'hF, 1'b1);
      push_row(32'hA0000004, 4'hF, 1'b1);
      @(negedge clk); chk("t2_no_overflow_at_full", overflow, 1'b0);
      step();
      push_row(32'hA0000005, 4'hF, 1'b0);
      @(negedge clk); chk("t2_overflow", overflow, 1'b1);
      step();
      bram_if.bram_gnt_c = 1'b1;
      repeat (6) step();
      chk("t2_four_writes", writes, 7);
      chk("t2_overflow_sticky", overflow, 1'b1);

      // Partial mask and zero mask both consume an address slot and a row count.
      do_start(10'h080, 10'd2, 10'd2);
      chk("t3_overflow_cleared", overflow, 1'b0);
      push_row(32'hDEADBEEF, 4'b0101, 1'b1);
      push_row(32'h01020304, 4'b0000, 1'b1);
      repeat (3) step();
      chk("t3_done", done_writer, 1'b1);

      // Zero rows: done immediately, nothing written.
      do_start(10'h100, 10'd1, 10'd0);
      @(negedge clk);
      chk("t4_done", done_writer, 1'b1);
      chk("t4_no_write", bram_if.bram_en_c, 1'b0);
      step();

      // Address accumulator wraps modulo 2^AWIDTH.
      do_start(10'h3FC, 10'd4, 10'd2);
      push_row(32'hCAFE0001, 4'hF, 1'b1);
      push_row(32'hCAFE0002, 4'hF, 1'b1);
      repeat (3) step();
      chk("t5_done", done_writer, 1'b1);
      chk("t5_write_count", writes, 11);

      // Reset with rows queued and grant denied: rows vanish without being written.
      bram_if.bram_gnt_c = 1'b0;
      do_start(10'h020, 10'd1, 10'd4);
      push_row(32'hBEEF0001, 4'hF, 1'b0);
      push_row(32'hBEEF0002, 4'hF, 1'b0);
      repeat (6) step();
`ifdef POOL_WRITER_STALL_CNT_EN
      @(negedge clk); chk("t6_stall_cycles", stall_cycles, 32'd7);
`endif
      chk("t6_req_before_reset", bram_if.bram_req_c, 1'b1);
      step();
      resetn = 1'b0;
      step();
      bram_if.bram_gnt_c = 1'b1;
      @(negedge clk);
      chk("t6_rst_req", bram_if.bram_req_c, 1'b0);
      chk("t6_rst_en", bram_if.bram_en_c, 1'b0);
      chk("t6_rst_addr", bram_if.bram_addr_c, '0);
      chk("t6_rst_wdata", bram_if.bram_wdata_c, '0);
      chk("t6_rst_done", done_writer, 1'b0);
`ifdef POOL_WRITER_STALL_CNT_EN
      chk("t6_rst_stall", stall_cycles, 32'd0);
`endif
      step();
      resetn = 1'b1;
      repeat (4) step();
      chk("t6_no_writes_after_reset", writes, 11);
      chk("scoreboard_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
